adma_desc_consumer: RTL and testbench

Per-channel reader of the DMA descriptor queue, on the channel-management side. It pops one 2D descriptor when the channel is enabled and a descriptor is available, then expands it into a stream of 1D row commands. Each row command carries source address, destination address and length, and goes to the AXI read/write engines. It reports descriptor completion and busy status to channel management. One instance is built per write channel.

---
 rtl/adma_desc_consumer.sv | 171 +++++++++++++++++
 tb/tb_adma_desc_consumer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_desc_consumer.sv
// Per-channel descriptor consumer: pops one 2D descriptor and expands it into 1D row commands.
// Optional macro ADMA_DESC_DONE_TRACK_EN holds completion until every issued row reports done.
module adma_desc_consumer #(
    parameter int SRC_ADDR_W   = 32,
    parameter int DST_ADDR_W   = 32,
    parameter int DMA_LENGTH_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    chn_en_i,
    input  logic [SRC_ADDR_W-1:0]   src_addr_i,
    input  logic [DST_ADDR_W-1:0]   dst_addr_i,
    input  logic [DMA_LENGTH_W-1:0] xfer_xlen_i,
    input  logic [DMA_LENGTH_W-1:0] xfer_ylen_i,
    input  logic [DMA_LENGTH_W-1:0] src_stride_i,
    input  logic [DMA_LENGTH_W-1:0] dst_stride_i,
    output logic                    desc_rd_vld_o,
    input  logic                    desc_rd_rdy_i,
    output logic [SRC_ADDR_W-1:0]   row_src_addr_o,
    output logic [DST_ADDR_W-1:0]   row_dst_addr_o,
    output logic [DMA_LENGTH_W-1:0] row_len_o,
    output logic                    row_last_o,
    output logic                    row_vld_o,
    input  logic                    row_rdy_i,
    input  logic                    row_done_i,
    output logic                    desc_done_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DMA_LENGTH_W-1:0] LEN_ONE = {{(DMA_LENGTH_W-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nxt;
    logic [SRC_ADDR_W-1:0]   src_addr;
    logic [DST_ADDR_W-1:0]   dst_addr;
    logic [DMA_LENGTH_W-1:0] row_len;
    logic [DMA_LENGTH_W-1:0] src_stride;
    logic [DMA_LENGTH_W-1:0] dst_stride;
    logic [DMA_LENGTH_W-1:0] rows_left;
    logic                    pop;
    logic                    row_hs;
    logic                    last_hs;
    logic                    zero_desc;

    // rst gating keeps the pop request low while reset is applied, whatever chn_en_i does
    assign desc_rd_vld_o  = (state == IDLE) && chn_en_i && !rst;
    assign row_vld_o      = (state == ISSUE);
    assign row_last_o     = (state == ISSUE) && (rows_left == LEN_ONE);
    assign desc_done_o    = (state == DONE);
    assign busy_o         = (state != IDLE);
    assign row_src_addr_o = src_addr;
    assign row_dst_addr_o = dst_addr;
    assign row_len_o      = row_len;

    assign pop       = desc_rd_vld_o && desc_rd_rdy_i;
    assign row_hs    = row_vld_o && row_rdy_i;
    assign last_hs   = row_hs && (rows_left == LEN_ONE);
    assign zero_desc = (xfer_xlen_i == '0) || (xfer_ylen_i == '0);

`ifdef ADMA_DESC_DONE_TRACK_EN
    localparam logic [DMA_LENGTH_W:0] OUT_ONE = {{DMA_LENGTH_W{1'b0}}, 1'b1};

    logic [DMA_LENGTH_W:0] outstanding;
    logic [DMA_LENGTH_W:0] outstanding_nxt;
    logic                  drained;

    // Outstanding-row count: a coincident issue and completion cancel, and completions never underflow
    always_comb begin
        outstanding_nxt = outstanding;
        if (row_hs && !row_done_i) begin
            outstanding_nxt = outstanding + OUT_ONE;
        end else if (!row_hs && row_done_i && (outstanding != '0)) begin
            outstanding_nxt = outstanding - OUT_ONE;
        end else begin
            outstanding_nxt = outstanding;
        end
    end

    // Outstanding-row count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_nxt;
        end
    end

    assign drained = (outstanding_nxt == '0);
`else
    logic unused_row_done;
    assign unused_row_done = row_done_i;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = zero_desc ? DONE : ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (last_hs) begin
`ifdef ADMA_DESC_DONE_TRACK_EN
                    state_nxt = WAIT;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = ISSUE;
                end
            end
            WAIT: begin
`ifdef ADMA_DESC_DONE_TRACK_EN
                if (drained) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
`else
                state_nxt = IDLE;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Descriptor capture on pop, then per-row address stepping with silent modulo wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_addr   <= '0;
            dst_addr   <= '0;
            row_len    <= '0;
            src_stride <= '0;
            dst_stride <= '0;
            rows_left  <= '0;
        end else if (pop) begin
            src_addr   <= src_addr_i;
            dst_addr   <= dst_addr_i;
            row_len    <= xfer_xlen_i;
            src_stride <= src_stride_i;
            dst_stride <= dst_stride_i;
            rows_left  <= xfer_ylen_i;
        end else if (row_hs) begin
            src_addr   <= src_addr + SRC_ADDR_W'(src_stride);
            dst_addr   <= dst_addr + DST_ADDR_W'(dst_stride);
            rows_left  <= rows_left - LEN_ONE;
        end
    end

endmodule

// File: tb/tb_adma_desc_consumer.sv
// Self-checking bench for adma_desc_consumer: directed scenarios plus randomized descriptors
// compared against an arithmetic row-list model.
module tb_adma_desc_consumer;

    logic        clk;
    logic        rst;
    logic        chn_en_i;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic [15:0] xfer_xlen_i;
    logic [15:0] xfer_ylen_i;
    logic [15:0] src_stride_i;
    logic [15:0] dst_stride_i;
    logic        desc_rd_vld_o;
    logic        desc_rd_rdy_i;
    logic [31:0] row_src_addr_o;
    logic [31:0] row_dst_addr_o;
    logic [15:0] row_len_o;
    logic        row_last_o;
    logic        row_vld_o;
    logic        row_rdy_i;
    logic        row_done_i;
    logic        desc_done_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    adma_desc_consumer #(
        .SRC_ADDR_W   (32),
        .DST_ADDR_W   (32),
        .DMA_LENGTH_W (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .chn_en_i       (chn_en_i),
        .src_addr_i     (src_addr_i),
        .dst_addr_i     (dst_addr_i),
        .xfer_xlen_i    (xfer_xlen_i),
        .xfer_ylen_i    (xfer_ylen_i),
        .src_stride_i   (src_stride_i),
        .dst_stride_i   (dst_stride_i),
        .desc_rd_vld_o  (desc_rd_vld_o),
        .desc_rd_rdy_i  (desc_rd_rdy_i),
        .row_src_addr_o (row_src_addr_o),
        .row_dst_addr_o (row_dst_addr_o),
        .row_len_o      (row_len_o),
        .row_last_o     (row_last_o),
        .row_vld_o      (row_vld_o),
        .row_rdy_i      (row_rdy_i),
        .row_done_i     (row_done_i),
        .desc_done_o    (desc_done_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one descriptor; entered and left just after a falling edge.
    task automatic run_desc(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] xlen, input logic [15:0] ylen,
                            input logic [15:0] sstr, input logic [15:0] dstr,
                            input int stall_pct, input int stall_row, input int stall_n,
                            input int drop_row);
        logic [31:0] exp_src[$];
        logic [31:0] exp_dst[$];
        int idx;
        int held;
        int guard;
        if (xlen != 16'd0) begin
            for (int i = 0; i < int'(ylen); i++) begin
                exp_src.push_back(src + 32'(i) * {16'd0, sstr});
                exp_dst.push_back(dst + 32'(i) * {16'd0, dstr});
            end
        end
        chn_en_i      = 1'b1;
        desc_rd_rdy_i = 1'b0;
        row_rdy_i     = 1'b0;
        row_done_i    = 1'b0;
        src_addr_i    = src;
        dst_addr_i    = dst;
        xfer_xlen_i   = xlen;
        xfer_ylen_i   = ylen;
        src_stride_i  = sstr;
        dst_stride_i  = dstr;
        repeat ($urandom_range(0, 2)) begin
            #1;
            chk("idle_wait_vld", 32'(desc_rd_vld_o), 32'd1);
            chk("idle_wait_busy", 32'(busy_o), 32'd0);
            @(negedge clk);
        end
        desc_rd_rdy_i = 1'b1;
        #1;
        chk("pop_vld", 32'(desc_rd_vld_o), 32'd1);
        chk("pop_busy", 32'(busy_o), 32'd0);
        chk("pop_done", 32'(desc_done_o), 32'd0);
        @(negedge clk);
        src_addr_i  = $urandom;
        dst_addr_i  = $urandom;
        xfer_xlen_i = 16'($urandom);
        xfer_ylen_i = 16'($urandom);
        idx   = 0;
        held  = 0;
        guard = 0;
        while (idx < exp_src.size() && guard < 400) begin
            if (idx == drop_row) chn_en_i = 1'b0;
            if (idx == stall_row && held < stall_n) begin
                row_rdy_i = 1'b0;
                held++;
            end else begin
                row_rdy_i = 1'($urandom_range(0, 99) >= stall_pct);
            end
`ifdef ADMA_DESC_DONE_TRACK_EN
            row_done_i = row_rdy_i;
`else
            row_done_i = 1'($urandom_range(0, 1));
`endif
            #1;
            chk("row_vld", 32'(row_vld_o), 32'd1);
            chk("row_src", row_src_addr_o, exp_src[idx]);
            chk("row_dst", row_dst_addr_o, exp_dst[idx]);
            chk("row_len", 32'(row_len_o), 32'(xlen));
            chk("row_last", 32'(row_last_o), 32'(idx == exp_src.size() - 1));
            chk("row_no_pop", 32'(desc_rd_vld_o), 32'd0);
            chk("row_busy", 32'(busy_o), 32'd1);
            chk("row_no_done", 32'(desc_done_o), 32'd0);
            @(negedge clk);
            if (row_rdy_i) idx++;
            guard++;
        end
        chk("rows_in_budget", 32'(idx), 32'(exp_src.size()));
        row_rdy_i  = 1'($urandom_range(0, 1));
        row_done_i = 1'b0;
`ifdef ADMA_DESC_DONE_TRACK_EN
        if (exp_src.size() > 0) begin
            #1;
            chk("wait_busy", 32'(busy_o), 32'd1);
            chk("wait_no_row", 32'(row_vld_o), 32'd0);
            chk("wait_no_done", 32'(desc_done_o), 32'd0);
            @(negedge clk);
        end
`endif
        #1;
        chk("done_pulse", 32'(desc_done_o), 32'd1);
        chk("done_no_row", 32'(row_vld_o), 32'd0);
        chk("done_busy", 32'(busy_o), 32'd1);
        chk("done_no_pop", 32'(desc_rd_vld_o), 32'd0);
        @(negedge clk);
        desc_rd_rdy_i = 1'b0;
        row_rdy_i     = 1'b0;
        #1;
        chk("after_done", 32'(desc_done_o), 32'd0);
        chk("after_busy", 32'(busy_o), 32'd0);
        if (drop_row >= 0) begin
            desc_rd_rdy_i = 1'b1;
            repeat (3) begin
                #1;
                chk("disabled_no_pop", 32'(desc_rd_vld_o), 32'd0);
                chk("disabled_idle", 32'(busy_o), 32'd0);
                @(negedge clk);
            end
            desc_rd_rdy_i = 1'b0;
            chn_en_i      = 1'b1;
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        rst           = 1'b1;
        chn_en_i      = 1'b1;
        desc_rd_rdy_i = 1'b1;
        src_addr_i    = 32'h0;
        dst_addr_i    = 32'h0;
        xfer_xlen_i   = 16'h0;
        xfer_ylen_i   = 16'h0;
        src_stride_i  = 16'h0;
        dst_stride_i  = 16'h0;
        row_rdy_i     = 1'b0;
        row_done_i    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pop", 32'(desc_rd_vld_o), 32'd0);
        chk("rst_row_vld", 32'(row_vld_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(desc_done_o), 32'd0);
        chk("rst_src", row_src_addr_o, 32'd0);
        chk("rst_len", 32'(row_len_o), 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        desc_rd_rdy_i = 1'b0;
        @(negedge clk);

        // basic 2D, backpressure on row 2, zero lengths, address wrap
        run_desc(32'h1000, 32'h8000, 16'd64, 16'd3, 16'h100, 16'h200, 0, -1, 0, -1);
        run_desc(32'h1000, 32'h8000, 16'd64, 16'd3, 16'h100, 16'h200, 0, 1, 5, -1);
        run_desc(32'h2000, 32'h9000, 16'd0, 16'd5, 16'h10, 16'h10, 0, -1, 0, -1);
        run_desc(32'h2000, 32'h9000, 16'd16, 16'd0, 16'h10, 16'h10, 0, -1, 0, -1);
        run_desc(32'hFFFF_FF80, 32'hFFFF_FFF0, 16'd8, 16'd2, 16'h100, 16'h40, 0, -1, 0, -1);
        // enable dropped during row 2 of 4
        run_desc(32'h4000, 32'hA000, 16'd32, 16'd4, 16'h80, 16'h80, 0, -1, 0, 1);

        // reset in the middle of row 2 of a 4-row descriptor
        chn_en_i      = 1'b1;
        desc_rd_rdy_i = 1'b1;
        src_addr_i    = 32'h5000;
        dst_addr_i    = 32'hB000;
        xfer_xlen_i   = 16'd8;
        xfer_ylen_i   = 16'd4;
        src_stride_i  = 16'h20;
        dst_stride_i  = 16'h20;
        @(negedge clk);
        desc_rd_rdy_i = 1'b0;
        row_rdy_i     = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_row_vld", 32'(row_vld_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(desc_done_o), 32'd0);
        chk("midrst_pop", 32'(desc_rd_vld_o), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        row_rdy_i = 1'b0;
        #1;
        chk("postrst_done", 32'(desc_done_o), 32'd0);
        chk("postrst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        run_desc(32'h6000, 32'hC000, 16'd12, 16'd3, 16'h30, 16'h60, 20, -1, 0, -1);

`ifdef ADMA_DESC_DONE_TRACK_EN
        begin
            int sched[$];
            int sent;
            int dones;
            int last_done;
            sent      = 0;
            dones     = 0;
            last_done = -1;
            chn_en_i      = 1'b1;
            desc_rd_rdy_i = 1'b1;
            src_addr_i    = 32'h7000;
            dst_addr_i    = 32'hD000;
            xfer_xlen_i   = 16'd32;
            xfer_ylen_i   = 16'd4;
            src_stride_i  = 16'h40;
            dst_stride_i  = 16'h40;
            @(negedge clk);
            desc_rd_rdy_i = 1'b0;
            for (int k = 1; k <= 26; k++) begin
                row_rdy_i  = (sent < 3) || (k >= 11);
                row_done_i = 1'b0;
                foreach (sched[j]) if (sched[j] == k) row_done_i = 1'b1;
                if (row_done_i) begin
                    dones++;
                    if (dones == 4) last_done = k;
                end
                #1;
                chk("trk_row_vld", 32'(row_vld_o), 32'(sent < 4));
                chk("trk_busy", 32'(busy_o), 32'(last_done < 0 || k <= last_done + 1));
                chk("trk_done", 32'(desc_done_o), 32'(last_done >= 0 && k == last_done + 1));
                if (sent < 4 && row_rdy_i) begin
                    sched.push_back(k + 10);
                    sent++;
                end
                @(negedge clk);
            end
            row_rdy_i  = 1'b0;
            row_done_i = 1'b0;
        end
`endif

        // randomized descriptors against the row-list model
        for (int n = 0; n < 8; n++) begin
            logic [15:0] rx;
            logic [15:0] ry;
            rx = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 4096));
            ry = 16'($urandom_range(0, 6));
            run_desc($urandom, $urandom, rx, ry, 16'($urandom), 16'($urandom), 30, -1, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
